// File: rtl/sqrt_root2_seq.sv
// Sequential 8-bit integer square root: restoring digit-by-digit method, one root bit per clock.
// Produces the 4-bit floor root, the 5-bit remainder and a perfect-square flag behind a start/busy/done handshake.
module sqrt_root2_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] radicand,
  output logic       busy,
  output logic       done,
  output logic [3:0] root,
  output logic [4:0] remainder,
  output logic       exact
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state_reg, state_next;
  logic [7:0] shift_reg, shift_next;
  logic [5:0] rem_reg, rem_next;
  logic [3:0] q_reg, q_next;
  logic [1:0] cnt_reg, cnt_next;
  logic [3:0] root_reg, root_next;
  logic [4:0] remo_reg, remo_next;
  logic       exact_reg, exact_next;

  logic [5:0] r_shift;
  logic [5:0] trial;
  logic [5:0] r_new;
  logic [3:0] q_new;

  // Radicand digit pairs are consumed MSB-first from the top of the shift register.
  always_comb begin
    r_shift = {rem_reg[3:0], shift_reg[7:6]};
    trial   = {q_reg, 2'b01};
    if (r_shift >= trial) begin
      r_new = r_shift - trial;
      q_new = {q_reg[2:0], 1'b1};
    end else begin
      r_new = r_shift;
      q_new = {q_reg[2:0], 1'b0};
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    rem_next   = rem_reg;
    q_next     = q_reg;
    cnt_next   = cnt_reg;
    root_next  = root_reg;
    remo_next  = remo_reg;
    exact_next = exact_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          shift_next = radicand;
          rem_next   = 6'd0;
          q_next     = 4'd0;
          cnt_next   = 2'd3;
          state_next = CALC;
        end
      end
      CALC: begin
        shift_next = {shift_reg[5:0], 2'b00};
        rem_next   = r_new;
        q_next     = q_new;
        cnt_next   = cnt_reg - 2'd1;
        if (cnt_reg == 2'd0) begin
          root_next  = q_new;
          remo_next  = r_new[4:0];
          exact_next = (r_new == 6'd0);
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shift_reg <= 8'd0;
      rem_reg   <= 6'd0;
      q_reg     <= 4'd0;
      cnt_reg   <= 2'd0;
      root_reg  <= 4'd0;
      remo_reg  <= 5'd0;
      exact_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      rem_reg   <= rem_next;
      q_reg     <= q_next;
      cnt_reg   <= cnt_next;
      root_reg  <= root_next;
      remo_reg  <= remo_next;
      exact_reg <= exact_next;
    end
  end

  // Handshake flags decode straight from the state register, so nothing is combinational from start.
  assign busy      = (state_reg == CALC);
  assign done      = (state_reg == DONE);
  assign root      = root_reg;
  assign remainder = remo_reg;
  assign exact     = exact_reg;

endmodule

// File: tb/tb_sqrt_root2_seq.sv
// Directed bench for sqrt_root2_seq: vector table, handshake/reset sequences, and a sweep of all radicands.
module tb_sqrt_root2_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] radicand;
  logic       busy;
  logic       done;
  logic [3:0] root;
  logic [4:0] remainder;
  logic       exact;

  int tests = 0;
  int fails = 0;

  sqrt_root2_seq dut (
    .clk(clk), .rst(rst), .start(start), .radicand(radicand),
    .busy(busy), .done(done), .root(root), .remainder(remainder), .exact(exact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic [3:0] r;
    logic [4:0] rem;
    logic       ex;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Issue one request from IDLE and wait for its done pulse; returns cycles from the accepting edge.
  task automatic run_op(input logic [7:0] x, output int lat);
    int guard;
    guard = 0;
    while ((busy || done) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    @(negedge clk);
    start = 1'b1;
    radicand = x;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", int'(busy), 1);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, ndone, er;
    logic [3:0] got_root;
    logic [4:0] got_rem;

    vecs[0] = '{8'd0,   4'd0,  5'd0,  1'b1};
    vecs[1] = '{8'd255, 4'd15, 5'd30, 1'b0};
    vecs[2] = '{8'd1,   4'd1,  5'd0,  1'b1};
    vecs[3] = '{8'd144, 4'd12, 5'd0,  1'b1};
    vecs[4] = '{8'd143, 4'd11, 5'd22, 1'b0};
    vecs[5] = '{8'd145, 4'd12, 5'd1,  1'b0};
    vecs[6] = '{8'd200, 4'd14, 5'd4,  1'b0};
    vecs[7] = '{8'd64,  4'd8,  5'd0,  1'b1};

    rst = 1'b1; start = 1'b0; radicand = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_root", int'(root), 0);
    check("rst_rem",  int'(remainder), 0);
    check("rst_exact", int'(exact), 0);
    ndone = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("idle_no_done", ndone, 0);
    $display("[TB] reset/idle: busy=%0d done=%0d", busy, done);

    foreach (vecs[i]) begin
      run_op(vecs[i].x, lat);
      $display("[TB] vec x=%0d root=%0d rem=%0d exact=%0d lat=%0d", vecs[i].x, root, remainder, exact, lat);
      check("vec_latency", lat, 4);
      check("vec_root", int'(root), int'(vecs[i].r));
      check("vec_rem", int'(remainder), int'(vecs[i].rem));
      check("vec_exact", int'(exact), int'(vecs[i].ex));
      check("vec_busy_in_done", int'(busy), 0);
    end

    // Handshake protection: spurious starts in CALC/DONE and a mid-flight radicand change.
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b1; radicand = 8'd200;
    @(posedge clk); #1;
    ndone = 0; got_root = 4'd0; got_rem = 5'd0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = (c == 1 || c == 3 || c == 5);
      radicand = (c == 2) ? 8'd77 : 8'd9;
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        got_root = root;
        got_rem = remainder;
        check("hs_done_edge", c, 4);
      end
    end
    start = 1'b0;
    $display("[TB] handshake: dones=%0d root=%0d rem=%0d", ndone, got_root, got_rem);
    check("hs_done_count", ndone, 1);
    check("hs_root", int'(got_root), 14);
    check("hs_rem", int'(got_rem), 4);

    // Reset two edges into a computation aborts it and zeroes the outputs.
    @(negedge clk);
    start = 1'b1; radicand = 8'd99;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_root", int'(root), 0);
    check("abort_rem", int'(remainder), 0);
    ndone = 0;
    repeat (8) begin
      check("abort_done_low", int'(done), 0);
      @(posedge clk); #1;
    end
    $display("[TB] abort: busy=%0d root=%0d rem=%0d", busy, root, remainder);
    run_op(8'd64, lat);
    $display("[TB] after abort x=64 root=%0d rem=%0d exact=%0d lat=%0d", root, remainder, exact, lat);
    check("post_abort_lat", lat, 4);
    check("post_abort_root", int'(root), 8);
    check("post_abort_rem", int'(remainder), 0);
    check("post_abort_exact", int'(exact), 1);

    // Sweep every radicand against a search-based reference root.
    for (int x = 0; x < 256; x++) begin
      er = 0;
      while ((er + 1) * (er + 1) <= x) er++;
      run_op(x[7:0], lat);
      $display("[TB] sweep x=%0d root=%0d rem=%0d exact=%0d", x, root, remainder, exact);
      check("sweep_lat", lat, 4);
      check("sweep_root", int'(root), er);
      check("sweep_rem", int'(remainder), x - er * er);
      check("sweep_exact", int'(exact), (x == er * er) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
